// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader and its RAM.
package prog_loader_pkg;

    localparam int unsigned AddrW    = 6;
    localparam int unsigned DataW    = 8;
    localparam int unsigned MemDepth = 64;

    typedef struct packed {
        logic [AddrW-1:0] phys_addr;
    } addr_t;

    typedef struct packed {
        logic [DataW-1:0] raw_data;
    } data_t;

    typedef enum logic [1:0] {
        OpNop     = 2'b00,
        OpWrite   = 2'b01,
        OpClear   = 2'b10,
        OpIllegal = 2'b11
    } loader_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StClr
    } loader_state_e;

    localparam int unsigned ErrCsum    = 0;
    localparam int unsigned ErrIllegal = 1;
    localparam int unsigned ErrTimeout = 2;

    localparam logic [AddrW-1:0] RegionNormal = 6'h00;
    localparam logic [AddrW-1:0] RegionSwi    = 6'h10;
    localparam logic [AddrW-1:0] RegionExc    = 6'h20;
    localparam logic [AddrW-1:0] RegionHwi    = 6'h30;

    function automatic loader_op_e decode_op(input logic [DataW-1:0] hdr);
        return loader_op_e'(hdr[7:6]);
    endfunction

endpackage

// File: rtl/prog_ram.sv
// 64x8 program RAM: one synchronous write port, one combinational read port, no reset.
module prog_ram
    import prog_loader_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [DataW-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [DataW-1:0] rdata
);

    logic [DataW-1:0] mem_q [MemDepth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents when a write targets the same address.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader that fills the program RAM and holds the CPU while a frame is in flight.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  addr_t      rd_addr,
    output data_t      rd_data,
    output logic       cpu_hold,
    output logic       done,
    output logic [2:0] err,
    input  logic       err_clr
);

    localparam int unsigned ToW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLimit = ToW'(TIMEOUT);

    loader_state_e    state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic [7:0]       sum_q, sum_d;
    logic [ToW-1:0]   to_q, to_d;
    logic             done_q, done_d;
    logic [2:0]       err_q, err_d;
    logic [2:0]       err_set;

    logic             accept;
    logic             ram_we;
    logic [DataW-1:0] ram_wdata;
    logic [DataW-1:0] ram_rdata;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        to_d      = '0;
        done_d    = 1'b0;
        err_set   = '0;
        ram_we    = 1'b0;
        ram_wdata = in_data;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (decode_op(in_data))
                        OpNop: ;
                        OpWrite: begin
                            addr_d  = in_data[5:0];
                            sum_d   = '0;
                            state_d = StLen;
                        end
                        OpClear: begin
                            addr_d  = '0;
                            state_d = StClr;
                        end
                        OpIllegal: err_set[ErrIllegal] = 1'b1;
                    endcase
                end
            end
            StLen: begin
                if (accept) begin
                    cnt_d   = in_data[5:0];
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + 6'd1;
                    sum_d  = sum_q + in_data;
                    if (cnt_q == '0) begin
                        state_d = StCsum;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    err_set[ErrCsum] = (in_data != sum_q);
                    done_d           = 1'b1;
                    state_d          = StIdle;
                end
            end
            StClr: begin
                ram_we    = 1'b1;
                ram_wdata = CLEAR_VALUE;
                addr_d    = addr_q + 6'd1;
                if (addr_q == 6'd63) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Mid-frame starvation watchdog; partial writes are deliberately left in place.
        if ((state_q == StLen || state_q == StData || state_q == StCsum) && !in_valid) begin
            to_d = to_q + ToW'(1);
            if (TIMEOUT != 0 && to_d == ToLimit) begin
                err_set[ErrTimeout] = 1'b1;
                state_d             = StIdle;
                to_d                = '0;
            end
        end

        err_d = (err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q != StClr);
    assign cpu_hold = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = data_t'(ram_rdata);

    prog_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (ram_wdata),
        .raddr (rd_addr.phys_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Randomised and directed bench for prog_loader against a frame-level reference model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    addr_t      rd_addr;
    data_t      rd_data;
    logic       cpu_hold;
    logic       done;
    logic [2:0] err;
    logic       err_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    bit rand_clr = 0;

    // Reference model: frame-level view of the loader.
    logic [7:0] m_mem [64];
    bit         m_known [64];
    int         m_phase;     // 0 idle, 1 expecting length, 2 data, 3 checksum
    int         m_clr_left;
    int         m_idle;
    int         m_left;
    int         m_addr;
    int         m_sum;
    bit         m_done;
    logic [2:0] m_err;

    prog_loader #(
        .TIMEOUT     (TO),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_clr_left = 0; m_idle = 0; m_done = 0; m_err = 3'b000;
        m_left = 0; m_addr = 0; m_sum = 0;
    endtask

    task automatic model_step();
        bit         acc;
        logic [2:0] new_err;
        acc     = in_valid && (m_clr_left == 0);
        new_err = 3'b000;
        m_done  = 0;
        if (m_clr_left > 0) begin
            m_mem[64 - m_clr_left]   = 8'h00;
            m_known[64 - m_clr_left] = 1;
            m_clr_left--;
            if (m_clr_left == 0) m_done = 1;
        end else if (m_phase == 0) begin
            m_idle = 0;
            if (acc) begin
                case (in_data[7:6])
                    2'b01: begin m_addr = int'(in_data[5:0]); m_sum = 0; m_phase = 1; end
                    2'b10: m_clr_left = 64;
                    2'b11: new_err[1] = 1'b1;
                    default: ;
                endcase
            end
        end else if (acc) begin
            m_idle = 0;
            case (m_phase)
                1: begin m_left = int'(in_data[5:0]) + 1; m_phase = 2; end
                2: begin
                    m_mem[m_addr]   = in_data;
                    m_known[m_addr] = 1;
                    m_addr = (m_addr + 1) % 64;
                    m_sum  = (m_sum + int'(in_data)) % 256;
                    m_left--;
                    if (m_left == 0) m_phase = 3;
                end
                default: begin
                    if (int'(in_data) != m_sum) new_err[0] = 1'b1;
                    m_done  = 1;
                    m_phase = 0;
                end
            endcase
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                new_err[2] = 1'b1;
                m_phase = 0;
                m_idle  = 0;
            end
        end
        m_err = (err_clr ? 3'b000 : m_err) | new_err;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison of every output against the model.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("in_ready", in_ready, (m_clr_left == 0));
            check("cpu_hold", cpu_hold, (m_phase != 0 || m_clr_left != 0));
            check("done", done, m_done);
            check("err", err, m_err);
            if (m_known[rd_addr.phys_addr])
                check("rd_data", rd_data.raw_data, m_mem[rd_addr.phys_addr]);
            if (done) n_done++;
        end
    end

    task automatic drive_idle();
        in_valid = 0;
        rd_addr.phys_addr = 6'($urandom);
        err_clr = rand_clr && ($urandom_range(0, 15) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        idle(gap);
        @(negedge clk);
        in_valid = 1;
        in_data  = b;
        rd_addr.phys_addr = 6'($urandom);
        err_clr = rand_clr && ($urandom_range(0, 15) == 0);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_wait", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic rd_check(input string name, input int a, input logic [7:0] exp);
        @(negedge clk);
        in_valid = 0;
        err_clr  = 0;
        rd_addr.phys_addr = 6'(a);
        #1 check(name, rd_data.raw_data, exp);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int lo;
        int n;
        int kind;
        int sum;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        rst_n = 0; in_valid = 0; in_data = 0; rd_addr = '0; err_clr = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 3'b000);
        rst_n = 1;
        idle(2);

        // Plain write of three bytes at 0x00.
        d0 = n_done;
        send_byte(8'h40, 0); send_byte(8'h02, 0);
        send_byte(8'hB7, 0); send_byte(8'hD0, 1); send_byte(8'hB6, 0);
        send_byte(8'h3D, 2);
        idle(3);
        check("w3_done_count", n_done - d0, 1);
        check("w3_err", err, 3'b000);
        rd_check("w3_ram0", 0, 8'hB7);
        rd_check("w3_ram1", 1, 8'hD0);
        rd_check("w3_ram2", 2, 8'hB6);

        // Address wrap-around from 62.
        send_byte(8'h7E, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'hAA, 0);
        idle(2);
        check("wrap_err", err, 3'b000);
        rd_check("wrap_ram62", 62, 8'h11);
        rd_check("wrap_ram63", 63, 8'h22);
        rd_check("wrap_ram0", 0, 8'h33);
        rd_check("wrap_ram1", 1, 8'h44);

        // Bad checksum keeps the written byte and still signals completion.
        d0 = n_done;
        send_byte(8'h50, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        idle(3);
        check("bad_csum_err", err, 3'b001);
        check("bad_csum_done", n_done - d0, 1);
        rd_check("bad_csum_ram16", 16, 8'h01);
        pulse_clr();
        idle(1);
        check("err_clr", err, 3'b000);

        // CLEAR: in_ready low for exactly 64 cycles.
        d0 = n_done;
        send_byte(8'h80, 0);
        lo = 0;
        forever begin
            @(negedge clk);
            drive_idle();
            if (in_ready || lo > 200) break;
            lo++;
        end
        check("clear_ready_low", lo, 64);
        idle(2);
        check("clear_done", n_done - d0, 1);
        for (int a = 0; a < 64; a++) rd_check("clear_ram", a, 8'h00);

        // Illegal header.
        send_byte(8'hC0, 0);
        idle(2);
        check("illegal_err", err, 3'b010);
        check("illegal_hold", cpu_hold, 0);
        pulse_clr();

        // Starvation after two of six data bytes.
        d0 = n_done;
        send_byte(8'h40, 0); send_byte(8'h05, 0); send_byte(8'hA1, 0); send_byte(8'hA2, 0);
        idle(TO + 2);
        check("timeout_err", err, 3'b100);
        check("timeout_hold", cpu_hold, 0);
        check("timeout_no_done", n_done - d0, 0);
        rd_check("timeout_ram0", 0, 8'hA1);
        rd_check("timeout_ram1", 1, 8'hA2);
        pulse_clr();

        // Reset in the middle of the data phase.
        send_byte(8'h40, 0); send_byte(8'h05, 0); send_byte(8'h5A, 0); send_byte(8'hA5, 0);
        rst_n = 0;
        #1;
        check("rst_mid_hold", cpu_hold, 0);
        check("rst_mid_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        send_byte(8'h42, 0); send_byte(8'h01, 0); send_byte(8'hC3, 0); send_byte(8'h3C, 0);
        send_byte(8'hFF, 0);
        idle(2);
        check("after_rst_err", err, 3'b000);
        rd_check("after_rst_ram0", 0, 8'h5A);
        rd_check("after_rst_ram1", 1, 8'hA5);
        rd_check("after_rst_ram2", 2, 8'hC3);
        rd_check("after_rst_ram3", 3, 8'h3C);

        // Randomised frames, gaps and error clears checked by the model each cycle.
        rand_clr = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                send_byte({2'b10, 6'($urandom)}, $urandom_range(0, 3));
            end else if (kind == 1) begin
                send_byte({2'b00, 6'($urandom)}, $urandom_range(0, 3));
            end else if (kind == 2) begin
                send_byte({2'b11, 6'($urandom)}, $urandom_range(0, 3));
            end else begin
                n = $urandom_range(0, 63);
                send_byte({2'b01, 6'($urandom)}, $urandom_range(0, 3));
                send_byte({2'($urandom), 6'(n)}, $urandom_range(0, 3));
                sum = 0;
                for (int k = 0; k <= n; k++) begin
                    b = 8'($urandom);
                    sum = (sum + int'(b)) % 256;
                    send_byte(b, $urandom_range(0, 3));
                end
                if ($urandom_range(0, 4) == 0) b = 8'($urandom);
                else b = 8'(sum);
                send_byte(b, $urandom_range(0, 3));
            end
        end
        rand_clr = 0;
        idle(80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
